alu_seq: RTL

Registered, handshaked successor to the combinational 16-bit ALU in the datapath. It accepts one operation at a time over a valid/ready interface and holds the program-status flags in an internal flag register. Single-cycle ops return one cycle after acceptance; the optional shift-add MUL takes BIT_WIDTH cycles. It sits between the decode/register-read stage and register-file writeback.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions, FSM states and opcode decode for alu_seq.
package alu_pkg;

    localparam logic [7:0] OP_AND    = 8'h01;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_XOR    = 8'h03;
    localparam logic [7:0] OP_ADD    = 8'h05;
    localparam logic [7:0] OP_SUB    = 8'h09;
    localparam logic [7:0] OP_CMP    = 8'h0B;
    localparam logic [7:0] OP_MOV    = 8'h0D;
    localparam logic [7:0] OP_MUL    = 8'h0E;
    localparam logic [7:0] OP_LSH    = 8'h84;
    localparam logic [7:0] OP_LSHI_L = 8'h80;
    localparam logic [7:0] OP_LSHI_R = 8'h81;

    localparam logic [3:0] NIB_ADDI = 4'h5;
    localparam logic [3:0] NIB_SUBI = 4'h9;
    localparam logic [3:0] NIB_CMPI = 4'hB;
    localparam logic [3:0] NIB_MOVI = 4'hD;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    typedef enum logic [3:0] {
        K_AND, K_OR, K_XOR, K_ADD, K_SUB, K_CMP, K_MOV, K_MUL, K_LSH, K_LSHI, K_BAD
    } op_kind_t;

    // Exact R-type/shift encodings win first; I-type forms match on the upper nibble alone.
    function automatic op_kind_t decode_op(input logic [7:0] op);
        case (op)
            OP_AND:               return K_AND;
            OP_OR:                return K_OR;
            OP_XOR:               return K_XOR;
            OP_ADD:               return K_ADD;
            OP_SUB:               return K_SUB;
            OP_CMP:               return K_CMP;
            OP_MOV:               return K_MOV;
            OP_MUL:               return K_MUL;
            OP_LSH:               return K_LSH;
            OP_LSHI_L, OP_LSHI_R: return K_LSHI;
            default: ;
        endcase
        case (op[7:4])
            NIB_ADDI: return K_ADD;
            NIB_SUBI: return K_SUB;
            NIB_CMPI: return K_CMP;
            NIB_MOVI: return K_MOV;
            default:  return K_BAD;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operation and result bus between decode and the sequential ALU.
interface alu_seq_if #(
    parameter int BIT_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int FLAG_WIDTH   = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_WIDTH-1:0] Opcode;
    logic [BIT_WIDTH-1:0]    Rdest;
    logic [BIT_WIDTH-1:0]    Rsrc_Imm;
    logic                    out_valid;
    logic [BIT_WIDTH-1:0]    Result;
    logic [FLAG_WIDTH-1:0]   Flags;
    logic                    op_err;

    modport master (
        output in_valid, Opcode, Rdest, Rsrc_Imm,
        input  in_ready, out_valid, Result, Flags, op_err
    );

    modport slave (
        input  in_valid, Opcode, Rdest, Rsrc_Imm,
        output in_ready, out_valid, Result, Flags, op_err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle for BIT_WIDTH cycles after start.
module alu_mul_seq #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIT_WIDTH-1:0]   a,
    input  logic [BIT_WIDTH-1:0]   b,
    output logic                   done,
    output logic [2*BIT_WIDTH-1:0] product
);
    localparam int CW = $clog2(BIT_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

    logic                   busy;
    logic [CW-1:0]          count;
    logic [2*BIT_WIDTH-1:0] mcand;
    logic [BIT_WIDTH-1:0]   mplier;
    logic [2*BIT_WIDTH-1:0] acc;

    // The final partial sum is exposed combinationally so the caller can register it on the done edge.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= {{BIT_WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 16-bit ALU with internal flag register.
// Define ALU_MUL_EN to build the sequential MUL opcode and its multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int FLAG_WIDTH   = 5
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(BIT_WIDTH);

    logic                    accept;
    logic                    pend;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [BIT_WIDTH-1:0]    a_q, b_q;
    logic [BIT_WIDTH-1:0]    result_q, res_n;
    logic [FLAG_WIDTH-1:0]   flags_q, flags_n;
    logic                    valid_q, err_q, err_n;
    logic [BIT_WIDTH:0]      sum, diff;
    logic [BIT_WIDTH-1:0]    neg_cnt;
    logic [7:0]              op8;
    op_kind_t                kind;

    assign op8     = 8'(op_q);
    assign kind    = decode_op(op8);
    assign neg_cnt = '0 - b_q;
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = {1'b0, a_q} - {1'b0, b_q};

`ifdef ALU_MUL_EN
    state_t                 state;
    logic                   mul_start, mul_done;
    logic [2*BIT_WIDTH-1:0] mul_product;
    logic [FLAG_WIDTH-1:0]  mul_flags;

    assign bus.in_ready = (state == ST_IDLE);
    assign mul_start    = accept && (8'(bus.Opcode) == OP_MUL);

    alu_mul_seq #(.BIT_WIDTH(BIT_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.Rdest),
        .b       (bus.Rsrc_Imm),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        mul_flags         = flags_q;
        mul_flags[FLAG_Z] = (mul_product[BIT_WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = mul_product[BIT_WIDTH-1];
        mul_flags[FLAG_C] = |mul_product[2*BIT_WIDTH-1:BIT_WIDTH];
    end
`else
    assign bus.in_ready = 1'b1;
`endif

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.Result    = result_q;
    assign bus.Flags     = flags_q;
    assign bus.op_err    = err_q;

    // Single-cycle datapath evaluated from the operands latched at acceptance.
    always_comb begin
        res_n   = result_q;
        flags_n = flags_q;
        err_n   = 1'b0;
        case (kind)
            K_AND: res_n = a_q & b_q;
            K_OR:  res_n = a_q | b_q;
            K_XOR: res_n = a_q ^ b_q;
            K_MOV: res_n = b_q;
            K_ADD: begin
                res_n           = sum[BIT_WIDTH-1:0];
                flags_n[FLAG_C] = sum[BIT_WIDTH];
                flags_n[FLAG_F] = (a_q[BIT_WIDTH-1] == b_q[BIT_WIDTH-1]) &&
                                  (sum[BIT_WIDTH-1] != a_q[BIT_WIDTH-1]);
                flags_n[FLAG_Z] = (sum[BIT_WIDTH-1:0] == '0);
                flags_n[FLAG_N] = sum[BIT_WIDTH-1];
            end
            K_SUB: begin
                res_n           = diff[BIT_WIDTH-1:0];
                flags_n[FLAG_C] = diff[BIT_WIDTH];
                flags_n[FLAG_F] = (a_q[BIT_WIDTH-1] != b_q[BIT_WIDTH-1]) &&
                                  (diff[BIT_WIDTH-1] != a_q[BIT_WIDTH-1]);
                flags_n[FLAG_Z] = (diff[BIT_WIDTH-1:0] == '0);
                flags_n[FLAG_N] = diff[BIT_WIDTH-1];
            end
            K_CMP: begin
                flags_n[FLAG_Z] = (a_q == b_q);
                flags_n[FLAG_L] = (a_q < b_q);
                flags_n[FLAG_N] = ($signed(a_q) < $signed(b_q));
            end
            K_LSH: begin
                if (b_q[BIT_WIDTH-1]) begin
                    res_n = (neg_cnt < BIT_WIDTH'(BIT_WIDTH)) ? (a_q >> neg_cnt) : '0;
                end else begin
                    res_n = (b_q < BIT_WIDTH'(BIT_WIDTH)) ? (a_q << b_q) : '0;
                end
            end
            K_LSHI: res_n = op8[0] ? (a_q >> b_q[CW-1:0]) : (a_q << b_q[CW-1:0]);
            default: begin
                res_n = '0;
                err_n = 1'b1;
            end
        endcase
    end

    // Accept latches operands; the following edge registers result and flags together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef ALU_MUL_EN
            state    <= ST_IDLE;
`endif
            pend     <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            pend    <= accept && !mul_start;
`else
            pend    <= accept;
`endif
            if (accept) begin
                op_q <= bus.Opcode;
                a_q  <= bus.Rdest;
                b_q  <= bus.Rsrc_Imm;
            end
            if (pend) begin
                result_q <= res_n;
                flags_q  <= flags_n;
                err_q    <= err_n;
                valid_q  <= 1'b1;
            end
`ifdef ALU_MUL_EN
            case (state)
                ST_IDLE: if (mul_start) state <= ST_MUL;
                ST_MUL: begin
                    if (mul_done) begin
                        result_q <= mul_product[BIT_WIDTH-1:0];
                        flags_q  <= mul_flags;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`endif
        end
    end
endmodule
